// File: rtl/gdr_pkt_pkg.sv
// ---------------------------------------------------------------------------
// gdr_pkt_pkg
// Shared definitions for the receive-side packet checker statistics.
//   NO_OF_RCHK  : number of packet checkers in the receive path
//   STATS_NUM   : number of statistics counters kept per block
//   STATS_IDX_e : counter index / read address of each statistic
//   isUnmapped  : true for a read address that selects no counter
// ---------------------------------------------------------------------------
package gdr_pkt_pkg;

   localparam int NO_OF_RCHK = 4;
   localparam int STATS_NUM  = 7;

   typedef enum logic [2:0] {
      CRC_OK   = 3'd0,
      CRC_ERR  = 3'd1,
      SOP      = 3'd2,
      EOP      = 3'd3,
      PKT      = 3'd4,
      MISS_SOP = 3'd5,
      MISS_EOP = 3'd6
   } STATS_IDX_e;

   function automatic logic isUnmapped(input logic [2:0] addr);
      return (addr >= 3'(STATS_NUM));
   endfunction

endpackage

// File: rtl/rx_stats_popcnt.sv
// ---------------------------------------------------------------------------
// rx_stats_popcnt
// Counts the set bits of an increment vector and registers the result.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   i_vec  in   WIDTH-bit increment vector, one bit per checker
//   o_cnt  out  registered number of set bits in i_vec
// ---------------------------------------------------------------------------
module rx_stats_popcnt #(
   parameter int WIDTH  = 4,
   parameter int OUT_WD = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  i_vec,
   output logic [OUT_WD-1:0] o_cnt
);

   logic [OUT_WD-1:0] w_bitSum;
   logic [OUT_WD-1:0] r_bitSum;

   // Plain ripple of single-bit additions; WIDTH is the checker count,
   // which stays small, so a tree adder brings nothing here.
   always_comb begin
      w_bitSum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_bitSum = w_bitSum + OUT_WD'(i_vec[i]);
      end
   end

   // Result register forms pipeline stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitSum <= '0;
      end else begin
         r_bitSum <= w_bitSum;
      end
   end

   assign o_cnt = r_bitSum;

endmodule

// File: rtl/rx_stats_accum.sv
// ---------------------------------------------------------------------------
// rx_stats_accum
// Accumulates per-checker increment pulses into seven statistics counters,
// with snapshot-to-shadow (optionally clearing) and a strobed read port.
// Pipeline: stage 1 gates/registers pulses, stage 2 popcounts, stage 3 adds.
// Configuration macro RX_STATS_SAT_EN: when defined, counters saturate at
// all-ones instead of wrapping.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cnt_en                1 = accept increment pulses
//   inc_rx_*              NO_CHK-bit increment pulses, one bit per checker
//   snap_req, snap_clr    copy live counters to shadow; optionally clear live
//   rd_req, rd_addr       read strobe and counter select (7 = unmapped)
//   rd_ack, rd_data       one-cycle acknowledge, shadow value zero-extended
//   rd_err                with rd_ack, 1 = unmapped address
//   snap_done             one-cycle pulse, snapshot completed
// ---------------------------------------------------------------------------
module rx_stats_accum
   import gdr_pkt_pkg::*;
#(
   parameter int CNTR_WD = 48,
   parameter int NO_CHK  = NO_OF_RCHK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cnt_en,
   input  logic [NO_CHK-1:0] inc_rx_crc_ok,
   input  logic [NO_CHK-1:0] inc_rx_crc_err,
   input  logic [NO_CHK-1:0] inc_rx_sop,
   input  logic [NO_CHK-1:0] inc_rx_eop,
   input  logic [NO_CHK-1:0] inc_rx_pkt,
   input  logic [NO_CHK-1:0] inc_rx_miss_sop,
   input  logic [NO_CHK-1:0] inc_rx_miss_eop,
   input  logic              snap_req,
   input  logic              snap_clr,
   input  logic              rd_req,
   input  logic [2:0]        rd_addr,
   output logic              rd_ack,
   output logic [63:0]       rd_data,
   output logic              rd_err,
   output logic              snap_done
);

   localparam int PC_WD = $clog2(NO_CHK + 1);

   logic [NO_CHK-1:0]  w_incVec   [STATS_NUM];
   logic [NO_CHK-1:0]  r_incGated [STATS_NUM];
   logic [PC_WD-1:0]   w_popCnt   [STATS_NUM];
   logic [CNTR_WD-1:0] w_nextCnt  [STATS_NUM];
   logic [CNTR_WD-1:0] r_liveCnt  [STATS_NUM];
   logic [CNTR_WD-1:0] r_shadowCnt[STATS_NUM];
   logic [CNTR_WD-1:0] w_rdSel;
   logic               w_rdUnmapped;
   logic               r_rdAck;
   logic [63:0]        r_rdData;
   logic               r_rdErr;
   logic               r_snapDone;

   assign w_incVec[CRC_OK]   = inc_rx_crc_ok;
   assign w_incVec[CRC_ERR]  = inc_rx_crc_err;
   assign w_incVec[SOP]      = inc_rx_sop;
   assign w_incVec[EOP]      = inc_rx_eop;
   assign w_incVec[PKT]      = inc_rx_pkt;
   assign w_incVec[MISS_SOP] = inc_rx_miss_sop;
   assign w_incVec[MISS_EOP] = inc_rx_miss_eop;

   // Stage 1: pulses are gated by cnt_en before they enter the pipeline,
   // so disabling counting never drops a pulse already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STATS_NUM; i++) begin
            r_incGated[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STATS_NUM; i++) begin
            r_incGated[i] <= w_incVec[i] & {NO_CHK{cnt_en}};
         end
      end
   end

   // Stage 2: one registered popcount per statistic.
   for (genvar g = 0; g < STATS_NUM; g++) begin : g_popcnt
      rx_stats_popcnt #(
         .WIDTH  (NO_CHK),
         .OUT_WD (PC_WD)
      ) u_popcnt (
         .clk   (clk),
         .rst_n (rst_n),
         .i_vec (r_incGated[g]),
         .o_cnt (w_popCnt[g])
      );
   end

   // Stage 3 adder. The saturating variant adds with a carry bit and clamps
   // to all-ones, so a counter that has hit the top stays there.
`ifdef RX_STATS_SAT_EN
   logic [CNTR_WD:0] w_wideSum [STATS_NUM];

   always_comb begin
      for (int i = 0; i < STATS_NUM; i++) begin
         w_wideSum[i] = {1'b0, r_liveCnt[i]} + (CNTR_WD + 1)'(w_popCnt[i]);
         w_nextCnt[i] = w_wideSum[i][CNTR_WD] ? {CNTR_WD{1'b1}}
                                              : w_wideSum[i][CNTR_WD-1:0];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < STATS_NUM; i++) begin
         w_nextCnt[i] = r_liveCnt[i] + CNTR_WD'(w_popCnt[i]);
      end
   end
`endif

   // Live and shadow counters. The shadow takes the post-add value so the
   // increment landing on the snapshot cycle is included; a clearing
   // snapshot restarts the live counter from that same increment rather
   // than from zero, so nothing arriving on the boundary is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STATS_NUM; i++) begin
            r_liveCnt[i]   <= '0;
            r_shadowCnt[i] <= '0;
         end
         r_snapDone <= 1'b0;
      end else begin
         for (int i = 0; i < STATS_NUM; i++) begin
            if (snap_req) begin
               r_shadowCnt[i] <= w_nextCnt[i];
               r_liveCnt[i]   <= snap_clr ? CNTR_WD'(w_popCnt[i]) : w_nextCnt[i];
            end else begin
               r_liveCnt[i]   <= w_nextCnt[i];
            end
         end
         r_snapDone <= snap_req;
      end
   end

   // Read mux over the shadow registers; the unmapped address selects zero.
   always_comb begin
      w_rdSel = '0;
      for (int i = 0; i < STATS_NUM; i++) begin
         if (rd_addr == 3'(i)) begin
            w_rdSel = r_shadowCnt[i];
         end
      end
      w_rdUnmapped = isUnmapped(rd_addr);
   end

   // Read response registers. The mux looks at the shadow before a
   // same-cycle snapshot updates it, which yields the pre-snapshot value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdAck  <= 1'b0;
         r_rdData <= '0;
         r_rdErr  <= 1'b0;
      end else begin
         r_rdAck <= rd_req;
         r_rdErr <= rd_req & w_rdUnmapped;
         if (rd_req) begin
            r_rdData <= 64'(w_rdSel);
         end
      end
   end

   assign rd_ack    = r_rdAck;
   assign rd_data   = r_rdData;
   assign rd_err    = r_rdErr;
   assign snap_done = r_snapDone;

endmodule

// File: tb/tb_rx_stats_accum.sv
// ---------------------------------------------------------------------------
// tb_rx_stats_accum
// Directed bench for rx_stats_accum built with NO_CHK=4, CNTR_WD=8 so the
// wrap / saturate boundary is reachable in a short run. Expected values are
// hand-computed; RX_STATS_SAT_EN selects the saturating expectation.
// ---------------------------------------------------------------------------
module tb_rx_stats_accum;
   import gdr_pkt_pkg::*;

`ifdef RX_STATS_SAT_EN
   localparam logic [63:0] WRAP_EXP = 64'd255;
`else
   localparam logic [63:0] WRAP_EXP = 64'd24;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cnt_en;
   logic [3:0]  inc_rx_crc_ok, inc_rx_crc_err, inc_rx_sop, inc_rx_eop;
   logic [3:0]  inc_rx_pkt, inc_rx_miss_sop, inc_rx_miss_eop;
   logic        snap_req, snap_clr, rd_req;
   logic [2:0]  rd_addr;
   logic        rd_ack, rd_err, snap_done;
   logic [63:0] rd_data;

   int checks = 0;
   int errors = 0;

   rx_stats_accum #(
      .CNTR_WD (8),
      .NO_CHK  (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cnt_en          (cnt_en),
      .inc_rx_crc_ok   (inc_rx_crc_ok),
      .inc_rx_crc_err  (inc_rx_crc_err),
      .inc_rx_sop      (inc_rx_sop),
      .inc_rx_eop      (inc_rx_eop),
      .inc_rx_pkt      (inc_rx_pkt),
      .inc_rx_miss_sop (inc_rx_miss_sop),
      .inc_rx_miss_eop (inc_rx_miss_eop),
      .snap_req        (snap_req),
      .snap_clr        (snap_clr),
      .rd_req          (rd_req),
      .rd_addr         (rd_addr),
      .rd_ack          (rd_ack),
      .rd_data         (rd_data),
      .rd_err          (rd_err),
      .snap_done       (snap_done)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the clock stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic setInc(input logic [2:0] idx, input logic [3:0] vec);
      case (idx)
         3'd0:    inc_rx_crc_ok   = vec;
         3'd1:    inc_rx_crc_err  = vec;
         3'd2:    inc_rx_sop      = vec;
         3'd3:    inc_rx_eop      = vec;
         3'd4:    inc_rx_pkt      = vec;
         3'd5:    inc_rx_miss_sop = vec;
         default: inc_rx_miss_eop = vec;
      endcase
   endtask

   // Hold one increment vector for a number of cycles, then release it.
   task automatic applyStimulus(input logic [2:0] idx, input logic [3:0] vec,
                                input int cycles);
      setInc(idx, vec);
      tick(cycles);
      setInc(idx, 4'b0000);
   endtask

   task automatic snapshot(input logic clr);
      snap_req = 1'b1;
      snap_clr = clr;
      tick();
      snap_req = 1'b0;
      snap_clr = 1'b0;
      checkOutput("snap_done", 64'(snap_done), 64'd1);
   endtask

   task automatic readCounter(input logic [2:0] addr, input string tag,
                              input logic [63:0] expData, input logic expErr);
      rd_req  = 1'b1;
      rd_addr = addr;
      tick();
      rd_req  = 1'b0;
      checkOutput({tag, "_ack"},  64'(rd_ack), 64'd1);
      checkOutput({tag, "_data"}, rd_data,     expData);
      checkOutput({tag, "_err"},  64'(rd_err), 64'(expErr));
   endtask

   initial begin
      rst_n = 1'b0;  cnt_en = 1'b1;
      inc_rx_crc_ok = '0; inc_rx_crc_err = '0; inc_rx_sop = '0; inc_rx_eop = '0;
      inc_rx_pkt = '0; inc_rx_miss_sop = '0; inc_rx_miss_eop = '0;
      snap_req = 1'b0; snap_clr = 1'b0; rd_req = 1'b0; rd_addr = 3'd0;

      // Reset state
      tick(2);
      checkOutput("rst_ack",   64'(rd_ack),    64'd0);
      checkOutput("rst_data",  rd_data,        64'd0);
      checkOutput("rst_err",   64'(rd_err),    64'd0);
      checkOutput("rst_snap",  64'(snap_done), 64'd0);
      rst_n = 1'b1;
      tick();

      // Read before any snapshot returns zero
      readCounter(3'(PKT), "nosnap", 64'd0, 1'b0);

      // 1011 for 10 cycles -> 30 packets
      applyStimulus(3'(PKT), 4'b1011, 10);
      tick(3);
      snapshot(1'b0);
      checkOutput("snap_pulse", 64'(snap_done), 64'd1);
      tick();
      checkOutput("snap_low", 64'(snap_done), 64'd0);
      readCounter(3'(PKT), "pkt30", 64'd30, 1'b0);
      readCounter(3'(CRC_OK), "crc0", 64'd0, 1'b0);

      // Clearing snapshot taken while stage 3 holds popcount 2
      applyStimulus(3'(CRC_OK), 4'b0001, 5);
      tick(3);
      inc_rx_crc_ok = 4'b0011;
      tick();
      inc_rx_crc_ok = 4'b0000;
      tick();
      snapshot(1'b1);
      readCounter(3'(CRC_OK), "clr_pre", 64'd7, 1'b0);
      readCounter(3'(PKT), "clr_pkt_pre", 64'd30, 1'b0);
      applyStimulus(3'(CRC_OK), 4'b0001, 3);
      tick(3);
      snapshot(1'b0);
      readCounter(3'(CRC_OK), "clr_post", 64'd5, 1'b0);
      readCounter(3'(PKT), "clr_pkt_post", 64'd0, 1'b0);

      // Snapshot while pulses are still in stages 1-2
      inc_rx_eop = 4'b1111;
      tick();
      inc_rx_eop = 4'b0000;
      snapshot(1'b0);
      readCounter(3'(EOP), "inflight_excl", 64'd0, 1'b0);
      tick(3);
      snapshot(1'b0);
      readCounter(3'(EOP), "inflight_land", 64'd4, 1'b0);

      // cnt_en low: pulses ignored
      cnt_en = 1'b0;
      inc_rx_crc_ok = 4'b1111; inc_rx_sop = 4'b1111; inc_rx_pkt = 4'b1111;
      tick(5);
      inc_rx_crc_ok = 4'b0000; inc_rx_sop = 4'b0000; inc_rx_pkt = 4'b0000;
      cnt_en = 1'b1;
      tick(3);
      snapshot(1'b0);
      readCounter(3'(SOP), "dis_sop", 64'd0, 1'b0);
      readCounter(3'(PKT), "dis_pkt", 64'd0, 1'b0);
      readCounter(3'(CRC_OK), "dis_crc", 64'd5, 1'b0);

      // Unmapped address
      readCounter(3'd7, "addr7", 64'd0, 1'b1);

      // Read and snapshot on the same cycle return the old shadow value
      applyStimulus(3'(EOP), 4'b0001, 3);
      tick(3);
      rd_req = 1'b1; rd_addr = 3'(EOP); snap_req = 1'b1;
      tick();
      rd_req = 1'b0; snap_req = 1'b0;
      checkOutput("same_ack",  64'(rd_ack),    64'd1);
      checkOutput("same_data", rd_data,        64'd4);
      checkOutput("same_snap", 64'(snap_done), 64'd1);

      // Back-to-back reads
      rd_req = 1'b1; rd_addr = 3'(EOP);
      tick();
      checkOutput("b2b0_ack",  64'(rd_ack), 64'd1);
      checkOutput("b2b0_data", rd_data,     64'd7);
      rd_addr = 3'(CRC_OK);
      tick();
      checkOutput("b2b1_ack",  64'(rd_ack), 64'd1);
      checkOutput("b2b1_data", rd_data,     64'd5);
      rd_req = 1'b0;
      tick();
      checkOutput("b2b_idle_ack", 64'(rd_ack), 64'd0);

      // 280 SOP increments in an 8-bit counter
      applyStimulus(3'(SOP), 4'b1111, 70);
      tick(3);
      snapshot(1'b1);
      readCounter(3'(SOP), "wrap", WRAP_EXP, 1'b0);

      // Asynchronous reset mid-burst, between clock edges
      inc_rx_crc_ok = 4'b1111;
      tick(2);
      rd_req = 1'b1; rd_addr = 3'(SOP); snap_req = 1'b1;
      tick();
      rd_req = 1'b0; snap_req = 1'b0;
      checkOutput("prerst_data", rd_data, WRAP_EXP);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_ack",  64'(rd_ack),    64'd0);
      checkOutput("async_data", rd_data,        64'd0);
      checkOutput("async_err",  64'(rd_err),    64'd0);
      checkOutput("async_snap", 64'(snap_done), 64'd0);
      inc_rx_crc_ok = 4'b0000;
      tick(2);
      rst_n = 1'b1;
      applyStimulus(3'(CRC_OK), 4'b0001, 2);
      tick(3);
      readCounter(3'(CRC_OK), "postrst_crc", 64'd0, 1'b0);
      readCounter(3'(SOP), "postrst_sop", 64'd0, 1'b0);
      snapshot(1'b0);
      readCounter(3'(CRC_OK), "postrst_new", 64'd2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
